// File: rtl/perceptron_host.sv
// Host-side sequencer for the perceptron core: loads weights and learning rate, streams
// samples through the go/sync/done handshake and captures classification, sum and weights.
module perceptron_host #(
  parameter int unsigned DW      = 6,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_l,
  // configuration
  input  logic          start,
  input  logic [DW-1:0] w0_init,
  input  logic [DW-1:0] w1_init,
  input  logic [DW-1:0] w2_init,
  input  logic [DW-1:0] n_init,
  // sample stream
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x1,
  input  logic [DW-1:0] s_x2,
  input  logic          s_label,
  input  logic          s_train,
  // results
  output logic          r_valid,
  output logic          r_class,
  output logic [DW-1:0] r_sum,
  output logic [DW-1:0] r_w0,
  output logic [DW-1:0] r_w1,
  output logic [DW-1:0] r_w2,
  output logic          busy,
  output logic          err,
  // core pins
  output logic          go,
  output logic          update,
  output logic          correct,
  output logic [1:0]    sel_out,
  output logic [DW-1:0] in_val,
  input  logic          sync,
  input  logic          done,
  input  logic          classification,
  input  logic [DW-1:0] out_val
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StLdW0, StLdW1, StLdW2, StLdN, StReady, StSendX1, StSendX2,
    StWait, StSettle, StRdW0, StRdW1, StRdW2, StResult, StErr
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, n_q, n_d;
  logic [DW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic          label_q, label_d, train_q, train_d;
  logic          r_class_q, r_class_d;
  logic [DW-1:0] r_sum_q, r_sum_d, r_w0_q, r_w0_d, r_w1_q, r_w1_d, r_w2_q, r_w2_d;

  // Next-state and WAIT timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLdW0;
      StLdW0:   if (sync) state_d = StLdW1;
      StLdW1:   if (sync) state_d = StLdW2;
      StLdW2:   if (sync) state_d = StLdN;
      StLdN:    if (sync) state_d = StReady;
      StReady:  if (s_valid) state_d = StSendX1;
      StSendX1: if (sync) state_d = StSendX2;
      // The core takes x2 without a sync, so leave after one cycle.
      StSendX2: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (done) begin
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) state_d = StErr;
        end
      end
      StSettle: state_d = train_q ? StRdW0 : StResult;
      StRdW0:   state_d = StRdW1;
      StRdW1:   state_d = StRdW2;
      StRdW2:   state_d = StResult;
      StResult: state_d = StReady;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
  end

  // Operand latches and result capture at the relevant exit edges.
  always_comb begin
    w0_d      = w0_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    n_d       = n_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    label_d   = label_q;
    train_d   = train_q;
    r_class_d = r_class_q;
    r_sum_d   = r_sum_q;
    r_w0_d    = r_w0_q;
    r_w1_d    = r_w1_q;
    r_w2_d    = r_w2_q;
    if (state_q == StIdle && start) begin
      w0_d = w0_init;
      w1_d = w1_init;
      w2_d = w2_init;
      n_d  = n_init;
    end
    if (state_q == StReady && s_valid) begin
      x1_d    = s_x1;
      x2_d    = s_x2;
      label_d = s_label;
      train_d = s_train;
    end
    // classification is taken one cycle after done, once the core has settled.
    if (state_q == StSettle) begin
      r_class_d = classification;
      r_sum_d   = out_val;
    end
    if (state_q == StRdW0) r_w0_d = out_val;
    if (state_q == StRdW1) r_w1_d = out_val;
    if (state_q == StRdW2) r_w2_d = out_val;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      w0_q      <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      n_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      label_q   <= 1'b0;
      train_q   <= 1'b0;
      r_class_q <= 1'b0;
      r_sum_q   <= '0;
      r_w0_q    <= '0;
      r_w1_q    <= '0;
      r_w2_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      n_q       <= n_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      label_q   <= label_d;
      train_q   <= train_d;
      r_class_q <= r_class_d;
      r_sum_q   <= r_sum_d;
      r_w0_q    <= r_w0_d;
      r_w1_q    <= r_w1_d;
      r_w2_q    <= r_w2_d;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    go      = 1'b0;
    in_val  = '0;
    s_ready = 1'b0;
    update  = 1'b0;
    correct = 1'b0;
    sel_out = 2'd0;
    r_valid = 1'b0;
    busy    = 1'b1;
    err     = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StLdW0:   begin go = 1'b1; in_val = w0_q; end
      StLdW1:   begin go = 1'b1; in_val = w1_q; end
      StLdW2:   begin go = 1'b1; in_val = w2_q; end
      StLdN:    begin go = 1'b1; in_val = n_q;  end
      StReady:  s_ready = 1'b1;
      StSendX1: begin go = 1'b1; in_val = x1_q; end
      StSendX2: begin go = 1'b1; in_val = x2_q; end
      StWait:   begin update = train_q; correct = label_q; end
      StSettle: sel_out = 2'd0;
      StRdW0:   sel_out = 2'd3;
      StRdW1:   sel_out = 2'd2;
      StRdW2:   sel_out = 2'd1;
      StResult: r_valid = 1'b1;
      StErr:    begin busy = 1'b0; err = 1'b1; end
      default:  busy = 1'b0;
    endcase
  end

  assign r_class = r_class_q;
  assign r_sum   = r_sum_q;
  assign r_w0    = r_w0_q;
  assign r_w1    = r_w1_q;
  assign r_w2    = r_w2_q;

endmodule

// File: tb/tb_perceptron_host.sv
// Bench for perceptron_host: scripted core responder, table of samples, result scoreboard.
module tb_perceptron_host;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] w0_init = '0, w1_init = '0, w2_init = '0, n_init = '0;
  logic s_valid = 1'b0, s_label = 1'b0, s_train = 1'b0;
  logic [DW-1:0] s_x1 = '0, s_x2 = '0;
  logic s_ready, r_valid, r_class, busy, err, go, update, correct;
  logic [DW-1:0] r_sum, r_w0, r_w1, r_w2, in_val, out_val;
  logic [1:0] sel_out;
  logic sync = 1'b0, done = 1'b0, classification;

  perceptron_host #(.DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_l(reset_l), .start(start),
    .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init), .n_init(n_init),
    .s_valid(s_valid), .s_ready(s_ready), .s_x1(s_x1), .s_x2(s_x2),
    .s_label(s_label), .s_train(s_train),
    .r_valid(r_valid), .r_class(r_class), .r_sum(r_sum),
    .r_w0(r_w0), .r_w1(r_w1), .r_w2(r_w2), .busy(busy), .err(err),
    .go(go), .update(update), .correct(correct), .sel_out(sel_out), .in_val(in_val),
    .sync(sync), .done(done), .classification(classification), .out_val(out_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Scripted core responder: sync follows go (with an optional stall on one value),
  // done rises in a chosen WAIT cycle; classification/out_val are wrong in the done cycle.
  int done_at = 0;
  int stall_left = 0;
  logic [DW-1:0] stall_on = '0;
  logic cls_cfg = 1'b0;
  logic [DW-1:0] rd_val [4];
  bit armed = 1'b0;
  int wcnt = 0;

  assign classification = done ? ~cls_cfg : cls_cfg;
  assign out_val = done ? {DW{1'b1}} : rd_val[sel_out];

  always @(negedge clk) begin
    done = 1'b0;
    if (go && stall_left > 0 && in_val == stall_on) begin
      sync = 1'b0;
      stall_left--;
    end else begin
      sync = go;
    end
    if (go) begin
      armed = 1'b1;
      wcnt = 0;
    end else if (armed) begin
      if (s_ready || !busy) begin
        armed = 1'b0;
      end else begin
        wcnt++;
        if (wcnt == done_at) begin
          done = 1'b1;
          armed = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic cls;
    logic [DW-1:0] sum, w0, w1, w2;
    int at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Result monitor: every r_valid pops one expectation.
  always @(negedge clk) begin
    if (r_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("r_latency", 32'(cyc), 32'(mon_e.at));
        check("r_class", 32'(r_class), 32'(mon_e.cls));
        check("r_sum", 32'(r_sum), 32'(mon_e.sum));
        check("r_w0", 32'(r_w0), 32'(mon_e.w0));
        check("r_w1", 32'(r_w1), 32'(mon_e.w1));
        check("r_w2", 32'(r_w2), 32'(mon_e.w2));
      end
    end
  end

  typedef struct {
    logic [DW-1:0] x1, x2;
    logic label, train;
    int done_at;
    logic cls;
    logic [DW-1:0] sum, w0r, w1r, w2r;
    logic hold;
  } vec_t;
  vec_t vecs[4];
  logic [DW-1:0] exp_w0 = '0, exp_w1 = '0, exp_w2 = '0;

  task automatic zero_check(string tag);
    check({tag, "_core"}, 32'({go, update, correct, sel_out, in_val}), 32'd0);
    check({tag, "_host"}, 32'({s_ready, r_valid, busy, err}), 32'd0);
    check({tag, "_result"}, 32'({r_class, r_sum, r_w0, r_w1, r_w2}), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_wait", 32'(s_ready), 32'd1);
  endtask

  task automatic do_config(input logic [DW-1:0] a, b, c, n, input int stall);
    int s, last;
    stall_on = b;
    stall_left = stall;
    start = 1'b1;
    w0_init = a; w1_init = b; w2_init = c; n_init = n;
    s = cyc;
    last = s + 5 + stall;
    for (int k = s + 1; k <= last; k++) begin
      @(negedge clk);
      start = 1'b0;
      w0_init = '1; w1_init = '1; w2_init = '1; n_init = '1;
      check("cfg_go", 32'(go), 32'(k < last));
      check("cfg_busy", 32'(busy), 32'd1);
      check("cfg_s_ready", 32'(s_ready), 32'(k == last));
      if (k == s + 1) check("cfg_w0", 32'(in_val), 32'(a));
      else if (k <= s + 2 + stall) check("cfg_w1", 32'(in_val), 32'(b));
      else if (k == s + 3 + stall) check("cfg_w2", 32'(in_val), 32'(c));
      else if (k == s + 4 + stall) check("cfg_n", 32'(in_val), 32'(n));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t, lat, d;
    exp_t e;
    done_at = v.done_at;
    cls_cfg = v.cls;
    rd_val[0] = v.sum; rd_val[3] = v.w0r; rd_val[2] = v.w1r; rd_val[1] = v.w2r;
    wait_ready();
    d = v.done_at;
    lat = v.train ? d + 7 : d + 4;
    if (v.train) begin
      exp_w0 = v.w0r; exp_w1 = v.w1r; exp_w2 = v.w2r;
    end
    t = cyc;
    e = '{v.cls, v.sum, exp_w0, exp_w1, exp_w2, t + lat};
    sb.push_back(e);
    s_valid = 1'b1; s_x1 = v.x1; s_x2 = v.x2; s_label = v.label; s_train = v.train;
    for (int c = t + 1; c <= t + lat + 1; c++) begin
      @(negedge clk);
      if (!v.hold || c >= t + lat) s_valid = 1'b0;
      // While s_valid is held outside READY, offer junk that must not be taken.
      if (v.hold) begin
        s_x1 = ~v.x1; s_x2 = ~v.x2; s_train = ~v.train;
      end
      check("go", 32'(go), 32'(c <= t + 2));
      if (c == t + 1) check("in_val_x1", 32'(in_val), 32'(v.x1));
      if (c == t + 2) check("in_val_x2", 32'(in_val), 32'(v.x2));
      check("update", 32'(update), 32'(v.train && c >= t + 3 && c <= t + 2 + d));
      check("correct", 32'(correct), 32'(v.label && c >= t + 3 && c <= t + 2 + d));
      check("s_ready", 32'(s_ready), 32'(c == t + lat + 1));
      if (c == t + 3 + d) check("sel_settle", 32'(sel_out), 32'd0);
      if (v.train && c == t + 4 + d) check("sel_rd_w0", 32'(sel_out), 32'd3);
      if (v.train && c == t + 5 + d) check("sel_rd_w1", 32'(sel_out), 32'd2);
      if (v.train && c == t + 6 + d) check("sel_rd_w2", 32'(sel_out), 32'd1);
    end
  endtask

  task automatic run_timeout();
    int t;
    done_at = 0;
    wait_ready();
    t = cyc;
    s_valid = 1'b1; s_x1 = 6'h01; s_x2 = 6'h02; s_label = 1'b1; s_train = 1'b1;
    for (int c = t + 1; c <= t + 19; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (c == t + 18) begin
        check("to_err_early", 32'(err), 32'd0);
        check("to_update", 32'(update), 32'd1);
      end
      if (c == t + 19) begin
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_s_ready", 32'(s_ready), 32'd0);
        check("to_core", 32'({go, update, correct}), 32'd0);
      end
    end
    start = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
    check("err_sticky", 32'(err), 32'd1);
    check("err_go", 32'(go), 32'd0);
    check("err_s_ready", 32'(s_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rd_val[i] = '0;
    vecs[0] = '{6'h11, 6'h22, 1'b0, 1'b0, 2, 1'b1, 6'h13, 6'h2A, 6'h2B, 6'h2C, 1'b1};
    vecs[1] = '{6'h05, 6'h07, 1'b1, 1'b1, 9, 1'b0, 6'h31, 6'h21, 6'h22, 6'h23, 1'b0};
    vecs[2] = '{6'h3F, 6'h00, 1'b0, 1'b1, 3, 1'b1, 6'h02, 6'h15, 6'h16, 6'h17, 1'b0};
    vecs[3] = '{6'h2A, 6'h15, 1'b1, 1'b0, 5, 1'b0, 6'h3E, 6'h00, 6'h3F, 6'h10, 1'b0};

    repeat (2) @(negedge clk);
    zero_check("reset");
    reset_l = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    do_config(6'h05, 6'h0A, 6'h0F, 6'h04, 0);

    // start in READY is ignored.
    start = 1'b1;
    w0_init = 6'h3F;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_ready", 32'(s_ready), 32'd1);
    check("ign_start_go", 32'(go), 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    run_timeout();

    reset_l = 1'b0;
    #1;
    zero_check("err_reset");
    exp_w0 = '0; exp_w1 = '0; exp_w2 = '0;
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);

    do_config(6'h05, 6'h0A, 6'h0F, 6'h04, 3);
    run_vec(vecs[0]);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_host.md
# perceptron_host

Host-side sequencer for the perceptron core's go/sync/done handshake. It loads initial weights and learning rate, streams (x1, x2, label) samples, optionally requests a training update, and captures each sample's classification, sum and post-update weights. It sits between a valid/ready sample source and the perceptron core's user pins, replacing manual pin wiggling by firmware or a testbench.

## Interface
- DW, 6: data width; must match the core's in_val/out_val.
- TIMEOUT, 16: maximum WAIT cycles allowed before done; counter width is $clog2(TIMEOUT+1).
- clk  in  1  clock.
- reset_l  in  1  reset, asynchronous, active-low; shared with the core.
- start  in  1  single-cycle pulse; samples the four init values; honoured only in IDLE.
- w0_init, w1_init, w2_init, n_init  in  DW  initial weights and learning rate.
- s_valid  in  1  sample offered.
- s_ready  out  1  host can accept a sample (READY state only).
- s_x1, s_x2  in  DW  sample features.
- s_label  in  1  desired class; drives `correct`.
- s_train  in  1  request a training update; drives `update`.
- r_valid  out  1  one-cycle result pulse.
- r_class  out  1  captured classification.
- r_sum  out  DW  captured weighted sum (sel_out=0).
- r_w0, r_w1, r_w2  out  DW  weights read back after a training sample; otherwise hold previous value.
- busy  out  1  high in every state except IDLE and ERR.
- err  out  1  sticky done-timeout flag.
- go, update, correct  out  1  to the core.
- sel_out  out  2  to the core; 3=w0, 2=w1, 1=w2, 0=sum.
- in_val  out  DW  to the core.
- sync, done, classification  in  1  from the core.
- out_val  in  DW  from the core.

## Operation
- All core-facing outputs and s_ready are Moore outputs, decoded from the state register and latched operand registers. There is no combinational path from core inputs to core outputs.
- States and transitions:
  - IDLE: all outputs 0. On start, latch the init values and go to LD_W0.
  - LD_W0, LD_W1, LD_W2, LD_N: go=1, in_val = latched w0/w1/w2/n. Advance at any edge where sync=1; otherwise hold go and in_val stable. LD_N goes to READY.
  - READY: s_ready=1, go=0. On s_valid&s_ready, latch x1, x2, label and train, then go to SEND_X1.
  - SEND_X1: go=1, in_val=x1. Advance on sync to SEND_X2.
  - SEND_X2: go=1, in_val=x2. Advance unconditionally after one cycle, because the core accepts x2 without a sync.
  - WAIT: go=0; update=train and correct=label held for the entire state.
    - Clear the timeout counter on entry; increment it each WAIT cycle without done.
    - done=1: go to SETTLE.
    - The TIMEOUT-th WAIT cycle passes without done: go to ERR.
  - SETTLE: sel_out=0. At the exit edge, capture classification into r_class and out_val into r_sum. Go to RD_W0 if train, else RESULT.
  - RD_W0, RD_W1, RD_W2: sel_out = 3, 2, 1. At each exit edge, capture out_val into r_w0, r_w1, r_w2. Then go to RESULT.
  - RESULT: r_valid=1 for one cycle, then READY.
  - ERR: err=1, s_ready=0, busy=0, core outputs 0. Exit only by reset.
- Boundary rules:
  - start outside IDLE is ignored.
  - s_valid outside READY is ignored; no handshake occurs.
  - update and correct are 0 in every state except WAIT.
  - Reset in any state returns IDLE with every output 0, including r_* and err. The core resets on the same reset_l, so both sides restart together.

## Timing
- Config: with sync immediate, start in cycle S gives LD_W0..LD_N in S+1..S+4 and s_ready=1 in S+5. Each withheld sync cycle adds one cycle.
- Sample handshake in cycle T, immediate sync:
  - SEND_X1 in T+1, SEND_X2 in T+2, WAIT from T+3.
- Inference: done arrives in T+4, so r_valid is in T+6.
- Training with no weight change: done in T+5, r_valid in T+10.
- Each core weight-update iteration adds 3 cycles. The worst case of 3 iterations puts done in WAIT cycle 12, inside the default TIMEOUT.
- classification is sampled in SETTLE, one cycle after done, never in the done cycle.
- Throughput: the next handshake is possible in the cycle after r_valid.

## Test plan
Stimulus is driven by a scripted core responder model.
- Config load: start with w0=0x05, w1=0x0A, w2=0x0F, n=0x04 and immediate sync -> go=1 with in_val 05, 0A, 0F, 04 in S+1..S+4; s_ready=1 in S+5; busy=1 from S+1.
- Inference: x1=0x11, x2=0x22, train=0; model raises done in WAIT cycle 2, classification=1, out_val=0x13 at sel_out=0 -> in_val 11 then 22; update=0 throughout; r_valid in T+6 with r_class=1, r_sum=0x13; r_w* unchanged.
- Training: label=1, train=1; done in WAIT cycle 9; out_val 0x21/0x22/0x23 at sel_out 3/2/1 -> update=1 and correct=1 through WAIT only; sel_out sequence 0, 3, 2, 1; r_w0=0x21, r_w1=0x22, r_w2=0x23.
- Sync stall: sync withheld 3 cycles on w1 -> go=1 and in_val=0x0A stable for 4 cycles; s_ready is delayed 3 cycles.
- Timeout: no done -> err=1 in the cycle after the 16th WAIT cycle; s_ready stays 0; s_valid and start are ignored; reset_l low then clears err and all outputs to 0.
- Ignored events: start pulsed in READY and s_valid high in WAIT -> no state change and no extra handshake.
